// File: rtl/npu_pkg.sv
// npu_pkg: types and default constants shared by the feature-RAM read path.
package npu_pkg;

  // Read-engine sequencing: wait for a command, issue reads, then drain the buffer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fram_rd_state_e;

  // Output buffer depth; it must be a power of two of at least 2.
  localparam int FRAM_RD_FIFO_DEPTH = 4;

endpackage

// File: rtl/fram_rd_fifo.sv
// fram_rd_fifo: small synchronous FIFO for the read engine's output stream.
// Array storage, head word visible combinationally on pop_data.
// The count runs to DEPTH, so full and empty are unambiguous.
module fram_rd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             wr_en;
  logic             rd_en;

  // A push into a full buffer is only taken when a pop frees the slot in the same cycle.
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // Storage write; the array carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy update; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fram_stream_reader.sv
// fram_stream_reader: strided sequential reader for the feature-RAM read port.
// Takes one (base, stride, count) command and issues one address per cycle.
// It lines up the 1-cycle read latency and retries reads the router refuses.
// Words come out in order on a valid/ready stream.
// Optional build macro FRAM_RD_CONFLICT_CNT_EN enables the saturating retry counter;
// without it conflict_cnt is tied to zero.
`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 10
`endif

module fram_stream_reader
  import npu_pkg::*;
#(
  parameter int ADDR_W     = `FRAM_ADDR_WIDTH,
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = FRAM_RD_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic [ADDR_W-1:0] rp_addr,
  input  logic [DATA_W-1:0] rp_rdata,
  input  logic              bank_conflict,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       conflict_cnt
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  fram_rd_state_e    state_reg;
  fram_rd_state_e    state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic              done_reg;

  logic              accept;
  logic              issue;
  logic              commit;
  logic              last_issue;
  logic              pop;
  logic              last_pop;
  logic              credit_ok;
  logic [FCW-1:0]    credit_sum;

  logic [DATA_W:0]   fifo_head;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept     = cmd_valid && cmd_ready;
  assign commit     = issue && !bank_conflict;
  assign last_issue = (issued_reg == count_reg - CNT_W'(1));
  assign pop        = m_valid && m_ready;
  assign last_pop   = pop && m_last;

  // A read may only go out if its word is guaranteed a slot, counting the one still in flight.
  assign credit_sum = fifo_count + FCW'(inflight_reg);
  assign credit_ok  = !fifo_full && (credit_sum < FCW'(FIFO_DEPTH));

  // Refused issues show the same address again; idle cycles keep the last issued address.
  assign rp_addr = issue ? addr_reg : last_addr_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: a zero-length command never leaves IDLE; RUN ends on the final committed read.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (cmd_count != '0)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (commit && last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs: handshake, busy flag and the per-cycle issue decision.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    issue     = 1'b0;
    case (state_reg)
      IDLE:  cmd_ready = 1'b1;
      RUN: begin
        busy  = 1'b1;
        issue = (issued_reg < count_reg) && credit_ok;
      end
      DRAIN: busy = 1'b1;
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Command capture and address walk; addresses wrap silently at ADDR_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      last_addr_reg <= '0;
      stride_reg    <= '0;
      count_reg     <= '0;
      issued_reg    <= '0;
    end else if (accept) begin
      addr_reg   <= cmd_base;
      stride_reg <= cmd_stride;
      count_reg  <= cmd_count;
      issued_reg <= '0;
    end else if (commit) begin
      last_addr_reg <= addr_reg;
      addr_reg      <= addr_reg + stride_reg;
      issued_reg    <= issued_reg + CNT_W'(1);
    end
  end

  // Read-latency alignment: the data of a committed read is captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= commit;
      inflight_last_reg <= commit && last_issue;
    end
  end

  // Completion pulse: one cycle after the last word pops, or right after a zero-length accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (accept && (cmd_count == '0)) || ((state_reg == DRAIN) && last_pop);
    end
  end

  assign done = done_reg;

  fram_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data ({inflight_last_reg, rp_rdata}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stream side: the head word is masked while empty so idle outputs read as zero.
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_last  = !fifo_empty && fifo_head[DATA_W];

`ifdef FRAM_RD_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_reg;

  // Refused-read counter: restarts with each command and sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_reg <= '0;
    end else if (accept) begin
      conflict_cnt_reg <= '0;
    end else if (issue && bank_conflict && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fram_stream_reader.sv
// tb_fram_stream_reader: scoreboard bench for fram_stream_reader.
// A memory model answers the read port; each accepted command pushes its expected words;
// a negedge monitor pops and compares every delivered beat and the done pulse.
module tb_fram_stream_reader;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base = '0;
  logic [AW-1:0] cmd_stride = '0;
  logic [CW-1:0] cmd_count = '0;
  logic [AW-1:0] rp_addr;
  logic [DW-1:0] rp_rdata = '0;
  logic          bank_conflict;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [15:0]   conflict_cnt;

  fram_stream_reader #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
    .rp_addr(rp_addr), .rp_rdata(rp_rdata), .bank_conflict(bank_conflict),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [1 << AW];
  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int ready_mode = 0;     // 0: always ready, 1: never ready, 2: random
  int cmode = 0;          // 0: conflict only at conflict_cycle, 2: random
  int conflict_cycle = -1;
  bit done_exp = 1'b0;
  bit zero_pend = 1'b0;
  bit prev_hold = 1'b0;
  logic [DW:0] prev_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Read-port model: data for the address seen in a cycle appears in the next cycle.
  initial begin
    logic [AW-1:0] cap;
    forever begin
      @(negedge clk);
      cap = rp_addr;
      @(posedge clk);
      #1;
      rp_rdata = mem[cap];
    end
  end

  // Sink readiness and router conflict generation.
  initial begin
    m_ready = 1'b0;
    bank_conflict = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (cmode == 2) bank_conflict = ($urandom_range(0, 4) == 0);
      else            bank_conflict = (cyc == conflict_cycle);
    end
  end

  // Monitor: compares delivered beats, stream stability and the done pulse.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_exp = 1'b0;
        zero_pend = 1'b0;
        prev_hold = 1'b0;
        continue;
      end
      if (done || done_exp || zero_pend) chk("done_pulse", 32'(done), 32'(done_exp | zero_pend));
      zero_pend = 1'b0;
      done_exp = 1'b0;
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_word", 32'({m_last, m_data}), 32'(prev_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra: got data %0h with no word expected", m_data);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 32'(m_data), 32'(b.data));
          chk("beat_last", 32'(m_last), 32'(b.last));
          done_exp = b.last;
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_word = {m_last, m_data};
    end
  end

  // Offer a command, wait for it to be taken, and queue the words it must return.
  task automatic issue_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int cnt, input int cflt_off, output int acc);
    bit ok;
    logic [AW-1:0] a;
    beat_t b;
    conflict_cycle = -1;
    acc = -1;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_base = base;
    cmd_stride = stride;
    cmd_count = CW'(cnt);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      a = base + AW'(i) * stride;
      b.data = mem[a];
      b.last = (i == cnt - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    if (cnt == 0) zero_pend = 1'b1;
    if (cflt_off > 0) conflict_cycle = acc + cflt_off - 1;
    $display("cmd base=%0h stride=%0h count=%0d accepted at cycle %0d", base, stride, cnt, acc);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (cmd_ready && !busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed command with per-cycle address checks from the accept onward.
  task automatic directed(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input int cnt, input int cflt_off, input bit chk_lat);
    logic [AW-1:0] ea[$];
    logic [AW-1:0] a;
    int acc;
    int n;
    for (int i = 0; i < cnt; i++) begin
      a = base + AW'(i) * stride;
      ea.push_back(a);
      if (cflt_off > 0 && i == cflt_off - 1) ea.push_back(a);
    end
    issue_cmd(base, stride, cnt, cflt_off, acc);
    for (int j = 0; j < ea.size(); j++) begin
      @(negedge clk);
      chk("rp_addr_seq", 32'(rp_addr), 32'(ea[j]));
      if (chk_lat) chk("first_valid_latency", 32'(m_valid), 32'(j >= 2));
    end
    if (chk_lat) begin
      n = ea.size();
      while (!done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("done_cycle", 32'(n), 32'd7);
    end
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [AW-1:0] held;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rp_addr", 32'(rp_addr), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic run, timing and back-to-back throughput.
    ready_mode = 0;
    cmode = 0;
    directed(10'h010, 10'd1, 4, 0, 1'b1);

    // A refused second issue repeats the same address.
    directed(10'h010, 10'd1, 4, 2, 1'b0);
`ifdef FRAM_RD_CONFLICT_CNT_EN
    chk("conflict_cnt_one", 32'(conflict_cnt), 32'd1);
`else
    chk("conflict_cnt_one", 32'(conflict_cnt), 32'd0);
`endif

    // Address wrap; the new accept also restarts the retry counter.
    directed(10'(1024 - 2), 10'd3, 3, 0, 1'b0);
    chk("conflict_cnt_cleared", 32'(conflict_cnt), 32'd0);

    // Zero-length command: no issue and no beat, done one cycle after accept.
    held = rp_addr;
    issue_cmd(10'h155, 10'd7, 0, 0, acc);
    repeat (3) begin
      @(negedge clk);
      chk("zero_no_issue", 32'(rp_addr), 32'(held));
      chk("zero_no_valid", 32'(m_valid), 32'd0);
    end
    wait_idle();

    // Sink stalled: issues stop once the buffer credit runs out.
    ready_mode = 1;
    issue_cmd(10'h100, 10'd1, 8, 0, acc);
    repeat (10) begin
      @(negedge clk);
      chk("stall_no_overissue", 32'(rp_addr <= 10'h103), 32'd1);
    end
    chk("stall_valid", 32'(m_valid), 32'd1);
    ready_mode = 0;
    wait_idle();

    // Reset while two words are buffered.
    ready_mode = 1;
    issue_cmd(10'h200, 10'd1, 8, 0, acc);
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", 32'(m_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_rp_addr", 32'(rp_addr), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_data", 32'(m_data), 32'd0);
    chk("mid_rst_m_last", 32'(m_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    directed(10'h040, 10'd2, 3, 0, 1'b0);

    // Randomised commands, offered back to back, with random stalls and conflicts.
    ready_mode = 2;
    cmode = 2;
    for (int k = 0; k < 30; k++) begin
      issue_cmd(10'($urandom), ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 3)) : 10'($urandom),
                int'($urandom_range(0, 10)), 0, acc);
    end
    wait_idle();
    cmode = 0;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fram_stream_reader.md
# fram_stream_reader

Sequential read engine for the feature-RAM read port of the bank router. Accepts one strided read command (base, stride, count), issues one read address per cycle, aligns the 1-cycle BRAM read latency, re-issues any read blocked by a same-bank write (`bank_conflict`), and delivers words in order on a valid/ready stream. It sits between the NPU datapath consumers (line buffers, PE array feeders) and the router's `rp_addr`/`rp_rdata` port.

## Interface
- `ADDR_W`, default `` `FRAM_ADDR_WIDTH ``: FRAM word-address width.
- `DATA_W`, default 16: data width; must equal the width of `` `DATA_RANGE ``.
- `CNT_W`, default 16: width of the command word count.
- `FIFO_DEPTH`, default 4: output buffer depth; power of two, ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offer.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_base` in ADDR_W: first word address.
- `cmd_stride` in ADDR_W: address increment per word.
- `cmd_count` in CNT_W: words to read; 0 is legal.
- `rp_addr` out ADDR_W: to router read port.
- `rp_rdata` in DATA_W: router read data, valid 1 cycle after the address.
- `bank_conflict` in 1: router conflict flag for the current `rp_addr`.
- `m_valid` out 1, `m_ready` in 1, `m_data` out DATA_W, `m_last` out 1: output stream.
- `busy` out 1: command accepted and not yet complete.
- `done` out 1: one-cycle pulse when the last word leaves the stream (or on a count-0 command).
- `conflict_cnt` out 16: retry counter (see Configuration).

## Operation
- Reset values: `cmd_ready`=1, `rp_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `conflict_cnt`=0; FIFO empty, state IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE: `cmd_valid`&`cmd_ready` latches base/stride/count. If count=0, `done` pulses next cycle and the block stays in IDLE. Otherwise go to RUN with `busy`=1.
- RUN: an issue is performed when issued < count and `fifo_count + inflight < FIFO_DEPTH`. An issue drives `rp_addr`=current address.
  - With `bank_conflict`=0 in the issue cycle, the read is committed: inflight flag set, address += stride (modulo 2^ADDR_W, wraps silently), issued++.
  - With `bank_conflict`=1, the read is discarded: same address held, re-issued the next eligible cycle, `conflict_cnt` increments.
  - In the cycle after a committed issue, `rp_rdata` is pushed into the FIFO, tagged last if it is word count-1.
  - When issued = count, go to DRAIN.
- DRAIN: no issues; `rp_addr` holds its last value. When the FIFO empties after the last-tagged word pops, `done` pulses, `busy` drops, and the state returns to IDLE.
- Stream: `m_data`/`m_last` stay stable while `m_valid`&!`m_ready`. Words are delivered in address-issue order, never dropped or duplicated.
- Width rules: address arithmetic is ADDR_W-bit unsigned with wrap. The count comparison is CNT_W unsigned.
- A `cmd_valid` while busy is not accepted and is held by the master.

## Timing
- Command accept to first `rp_addr` issue: 1 cycle. First `m_valid`: 2 cycles after the first committed issue when no conflict occurs.
- Throughput: 1 word/cycle with `m_ready` held high and no conflicts. The credit check prevents FIFO overflow even with one read in flight.
- A conflict costs exactly 1 cycle per occurrence.
- Simultaneous FIFO push and pop when full-minus-inflight is legal; the count is unchanged.
- Reset mid-command: all state clears immediately (asynchronous reset); in-flight data is discarded, no `done` is produced, and the block is ready in IDLE after `rst_n` rises.

## Configuration
- `FRAM_RD_CONFLICT_CNT_EN` defined: `conflict_cnt` is a 16-bit counter of discarded reads. It saturates at 0xFFFF and clears on reset and on each command accept.
- Not defined: `conflict_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `npu_pkg`: the state enum `fram_rd_state_e` (IDLE/RUN/DRAIN) and a default `FRAM_RD_FIFO_DEPTH` constant.
- Sub-module `fram_rd_fifo`: synchronous FIFO with push, pop, data, count, and full/empty outputs. The top-level block owns the issue, credit, and FSM logic.

## Test plan
- Command base=0x010, stride=1, count=4, `m_ready`=1, no conflict: `rp_addr` takes 0x010..0x013 on consecutive cycles; 4 beats in order, `m_last` on beat 4, `done` one cycle after the last pop.
- Same command with `bank_conflict`=1 on the 2nd issue only: 0x011 is issued twice, output data is unchanged and in order, `conflict_cnt`=1 (macro on) / 0 (macro off).
- count=8, `m_ready`=0 for 10 cycles: issues stop at FIFO_DEPTH=4 words with no overflow; after `m_ready`=1, all 8 words arrive.
- base=2^ADDR_W-2, stride=3, count=3: addresses are 2^ADDR_W-2, 1, 4 (wrap).
- count=0: no `rp_addr` issue, no `m_valid`, `done` pulses 1 cycle after accept.
- `rst_n` low mid-RUN with 2 words buffered: all outputs return to reset values at once, no `done`, and a new command is accepted afterwards.
